// File: rtl/dmem_hs.sv
// dmem_hs: byte-addressable data memory with valid/ready request and
// response channels, a configurable access latency, byte/half/word
// accesses with sign/zero extension and alignment/range error reporting.
// Optional statistics counters are built when DMEM_HS_STATS_EN is defined.
//
// Handshake: a request transfers on the rising clk_i edge where
// req_valid_i & req_ready_o are both 1; a response transfers on the edge
// where rsp_valid_o & rsp_ready_i are both 1. Once rsp_valid_o is raised
// it, rsp_rdata_o and rsp_err_o stay stable until that transfer.
module dmem_hs #(
  parameter int MEM_SIZE   = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [1:0]            dbg_state_o
`ifdef DMEM_HS_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_rd_o,
  output logic [CNT_WIDTH-1:0]  stat_wr_o,
  output logic [CNT_WIDTH-1:0]  stat_err_o
`endif
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]         cnt_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic accept;
  logic complete;

  // Access fields: live inputs on the accept edge (LATENCY = 1 completes
  // there), latched copies afterwards.
  logic                  s_we;
  logic [1:0]            s_size;
  logic                  s_uns;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IDX_W-1:0]      s_idx;
  logic [LANE_W-1:0]     lane;
  logic [LANE_W+2:0]     shamt;
  logic                  s_err;
  logic [DATA_WIDTH-1:0] word_rd;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] merged;

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign dbg_state_o = state_q;

  assign accept   = req_valid_i & req_ready_o;
  assign complete = ((state_q == S_WAIT) && (cnt_q == '0)) ||
                    (accept && (LATENCY == 1));

  // Decode the access: lanes, range/alignment error, load result, store merge.
  always_comb begin
    s_we    = (state_q == S_IDLE) ? req_we_i       : we_q;
    s_size  = (state_q == S_IDLE) ? req_size_i     : size_q;
    s_uns   = (state_q == S_IDLE) ? req_unsigned_i : uns_q;
    s_addr  = (state_q == S_IDLE) ? req_addr_i     : addr_q;
    s_wdata = (state_q == S_IDLE) ? req_wdata_i    : wdata_q;

    word_idx = s_addr >> LANE_W;
    s_idx    = word_idx[IDX_W-1:0];
    lane     = s_addr[LANE_W-1:0];
    shamt    = {lane, 3'b000};

    s_err = (word_idx >= ADDR_WIDTH'(MEM_SIZE)) ||
            (s_size == 2'd3) ||
            ((s_size == 2'd1) && s_addr[0]) ||
            ((s_size == 2'd2) && (lane != '0));

    word_rd = s_err ? '0 : mem[s_idx];
    shifted = word_rd >> shamt;

    case (s_size)
      2'd0: begin
        load_ext = s_uns ? DATA_WIDTH'(shifted[7:0])
                         : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        mask     = DATA_WIDTH'(8'hFF) << shamt;
      end
      2'd1: begin
        load_ext = s_uns ? DATA_WIDTH'(shifted[15:0])
                         : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        mask     = DATA_WIDTH'(16'hFFFF) << shamt;
      end
      default: begin
        load_ext = shifted;
        mask     = '1;
      end
    endcase

    merged = (word_rd & ~mask) | ((s_wdata << shamt) & mask);
  end

  // Next-state logic for the IDLE -> WAIT -> RESP transaction sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, latency counter, latched request and registered response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= CW'(LATENCY - 1);
        we_q    <= req_we_i;
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (complete) begin
        err_q   <= s_err;
        rdata_q <= (s_err || s_we) ? '0 : load_ext;
      end
    end
  end

  // Word array: word i resets to i; stores merge the addressed lanes.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= DATA_WIDTH'(i);
    end else if (complete && s_we && !s_err) begin
      mem[s_idx] <= merged;
    end
  end

`ifdef DMEM_HS_STATS_EN
  logic [CNT_WIDTH-1:0] rd_cnt_q, wr_cnt_q, err_cnt_q;

  assign stat_rd_o  = rd_cnt_q;
  assign stat_wr_o  = wr_cnt_q;
  assign stat_err_o = err_cnt_q;

  // Saturating counters, bumped once per response handshake.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if ((state_q == S_RESP) && rsp_ready_i) begin
      if (err_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      end else if (we_q) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 1'b1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs: directed, table-driven bench for dmem_hs (default parameters),
// plus hand-written sequences for back-pressure and mid-transaction reset.
// Statistics outputs are checked when DMEM_HS_STATS_EN is defined.
module tb_dmem_hs;

  localparam int MEM_SIZE = 64;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int LAT      = 2;
  localparam int CW       = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_we_i = 1'b0;
  logic [1:0]    req_size_i = 2'd0;
  logic          req_unsigned_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic [1:0]    dbg_state_o;
`ifdef DMEM_HS_STATS_EN
  logic [CW-1:0] stat_rd_o, stat_wr_o, stat_err_o;
`endif

  dmem_hs #(
    .MEM_SIZE(MEM_SIZE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .LATENCY(LAT), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .dbg_state_o(dbg_state_o)
`ifdef DMEM_HS_STATS_EN
    , .stat_rd_o(stat_rd_o), .stat_wr_o(stat_wr_o), .stat_err_o(stat_err_o)
`endif
  );

  // Clock
  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_rd = 0, exp_wr = 0, exp_err = 0;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic [DW-1:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive a request at a negedge, wait for accept, return at the negedge after it.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    int t;
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
    t = 0;
    while (!req_ready_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    if (t == 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Count negedges from the accept edge until rsp_valid_o is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic handshake();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid_o}, 32'd0);
  endtask

  task automatic count(input logic we, input logic err);
    if (err) exp_err++;
    else if (we) exp_wr++;
    else exp_rd++;
  endtask

  task automatic chk_stats(input string tag);
`ifdef DMEM_HS_STATS_EN
    chk({tag, "_stat_rd"},  DW'(stat_rd_o),  DW'(exp_rd));
    chk({tag, "_stat_wr"},  DW'(stat_wr_o),  DW'(exp_wr));
    chk({tag, "_stat_err"}, DW'(stat_err_o), DW'(exp_err));
`else
    if (tag.len() < 0) $display("unused %s", tag);
`endif
  endtask

  initial begin
    int lat;
    string nm;
    logic [DW-1:0] held;

    // we size uns addr wdata exp_rdata exp_err
    vecs[0]  = mk(0, 2, 0, 32'h14,  32'h0,        32'h00000005, 0);
    vecs[1]  = mk(1, 2, 0, 32'h20,  32'hDEADBEEF, 32'h0,        0);
    vecs[2]  = mk(1, 0, 0, 32'h21,  32'hFFFFFF7F, 32'h0,        0);
    vecs[3]  = mk(0, 2, 0, 32'h20,  32'h0,        32'hDEAD7FEF, 0);
    vecs[4]  = mk(0, 1, 1, 32'h22,  32'h0,        32'h0000DEAD, 0);
    vecs[5]  = mk(0, 1, 0, 32'h22,  32'h0,        32'hFFFFDEAD, 0);
    vecs[6]  = mk(0, 0, 0, 32'h21,  32'h0,        32'h0000007F, 0);
    vecs[7]  = mk(1, 2, 0, 32'h20,  32'h80000000, 32'h0,        0);
    vecs[8]  = mk(0, 0, 0, 32'h23,  32'h0,        32'hFFFFFF80, 0);
    vecs[9]  = mk(0, 0, 1, 32'h23,  32'h0,        32'h00000080, 0);
    vecs[10] = mk(1, 1, 0, 32'h01,  32'h00001234, 32'h0,        1);
    vecs[11] = mk(0, 2, 0, 32'h00,  32'h0,        32'h00000000, 0);
    vecs[12] = mk(0, 2, 0, 32'h100, 32'h0,        32'h0,        1);
    vecs[13] = mk(1, 2, 0, 32'h100, 32'h55555555, 32'h0,        1);
    vecs[14] = mk(0, 2, 0, 32'hFC,  32'h0,        32'h0000003F, 0);
    vecs[15] = mk(0, 3, 0, 32'h00,  32'h0,        32'h0,        1);
    vecs[16] = mk(0, 2, 0, 32'h06,  32'h0,        32'h0,        1);
    vecs[17] = mk(1, 1, 0, 32'h0A,  32'hFFFFABCD, 32'h0,        0);
    vecs[18] = mk(0, 2, 0, 32'h08,  32'h0,        32'hABCD0002, 0);
    vecs[19] = mk(0, 0, 1, 32'h0B,  32'h0,        32'h000000AB, 0);

    // Reset
    repeat (3) @(negedge clk_i);
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rdata", rsp_rdata_o, 32'd0);
    chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state_o}, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Table-driven vectors, applied in order (memory state carries over).
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      wait_rsp(lat);
      nm = $sformatf("v%0d", i);
      chk({nm, "_lat"}, DW'(lat), DW'(LAT));
      chk({nm, "_rdata"}, rsp_rdata_o, vecs[i].exp_rdata);
      chk({nm, "_err"}, {31'd0, rsp_err_o}, {31'd0, vecs[i].exp_err});
      handshake();
      count(vecs[i].we, vecs[i].exp_err);
    end
    chk_stats("table");

    // Back-pressure: response held, second request waits for handshake.
    issue(1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", DW'(lat), DW'(LAT));
    held = rsp_rdata_o;
    chk("bp_rdata", held, 32'h00000001);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2;
    req_unsigned_i = 1'b0; req_addr_i = 32'h0C;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      chk("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
      chk("bp_rdata_hold", rsp_rdata_o, 32'h00000001);
      chk("bp_err_hold", {31'd0, rsp_err_o}, 32'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    count(1'b0, 1'b0);
    chk("bp_ready_after_hs", {31'd0, req_ready_o}, 32'd1);
    chk("bp_valid_after_hs", {31'd0, rsp_valid_o}, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("bp_second_accepted", {31'd0, req_ready_o}, 32'd0);
    wait_rsp(lat);
    chk("bp2_lat", DW'(lat), DW'(LAT));
    chk("bp2_rdata", rsp_rdata_o, 32'h00000003);
    handshake();
    count(1'b0, 1'b0);
    chk_stats("bp");

    // Reset during WAIT of a store: aborted, no response, no write.
    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hCAFEF00D);
    chk("ab_in_wait", {30'd0, dbg_state_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("ab_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("ab_rst_ready", {31'd0, req_ready_o}, 32'd1);
    chk("ab_rst_rdata", rsp_rdata_o, 32'd0);
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    chk_stats("ab");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk("ab_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
    wait_rsp(lat);
    chk("ab_word2", rsp_rdata_o, 32'h00000002);
    chk("ab_word2_err", {31'd0, rsp_err_o}, 32'd0);
    handshake();
    count(1'b0, 1'b0);
    chk_stats("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
